// File: rtl/hamming32t26d_scrub_reg.sv
// Protected 32-bit SECDED storage register with continuous decode, scrub write-back,
// sticky double-error flag and a saturating corrected-upset counter.
module hamming32t26d_scrub_reg #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [31:0]          hv_i,
  input  logic                 clr_i,
  output logic [25:0]          data_o,
  output logic                 sec_o,
  output logic                 ded_o,
  output logic [CNT_WIDTH-1:0] sec_cnt_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCRUB = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Syndrome bit k covers every position whose index has bit k set.
  function automatic logic [4:0] calc_syndrome(input logic [31:0] v);
    logic [4:0] s;
    s = 5'd0;
    for (int j = 1; j < 32; j++) begin
      for (int k = 0; k < 5; k++) begin
        if (((j >> k) & 1) == 1) begin
          s[k] = s[k] ^ v[j];
        end
      end
    end
    return s;
  endfunction

  function automatic logic calc_parity(input logic [31:0] v);
    return ^v;
  endfunction

  // Non-power-of-two positions carry data bits 0..25 in ascending order.
  function automatic logic [25:0] extract_data(input logic [31:0] v);
    logic [25:0] d;
    int          n;
    d = 26'd0;
    n = 0;
    for (int j = 1; j < 32; j++) begin
      if ((j & (j - 1)) != 0) begin
        d[n] = v[j];
        n++;
      end
    end
    return d;
  endfunction

  state_t                 state_r, state_n_s;
  logic [31:0]            cw_r, fix_q_r, fix_s;
  logic [25:0]            data_r;
  logic                   sec_r, ded_r, busy_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic [4:0]             syn_s;
  logic                   par_s, is_sec_s, is_ded_s;
  logic                   load_s, wb_s, latch_s, set_ded_s;

  // Combinational decode and single-bit correction of the stored word.
  always_comb begin
    syn_s    = calc_syndrome(cw_r);
    par_s    = calc_parity(cw_r);
    is_sec_s = par_s;
    is_ded_s = (!par_s) && (syn_s != 5'd0);
    if (is_sec_s) begin
      fix_s = cw_r ^ (32'd1 << syn_s);
    end else begin
      fix_s = cw_r;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state logic; a write always returns the FSM to IDLE.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (we_i) begin
          state_n_s = ST_IDLE;
        end else if (is_sec_s) begin
          state_n_s = ST_SCRUB;
        end else if (is_ded_s) begin
          state_n_s = ST_FAULT;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_SCRUB: state_n_s = ST_IDLE;
      ST_FAULT: begin
        if (we_i || clr_i) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_FAULT;
        end
      end
      default:  state_n_s = ST_IDLE;
    endcase
  end

  // Control strobes for the datapath.
  always_comb begin
    load_s    = we_i;
    wb_s      = 1'b0;
    latch_s   = 1'b0;
    set_ded_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        latch_s   = (!we_i) && is_sec_s;
        set_ded_s = (!we_i) && (!is_sec_s) && is_ded_s;
      end
      ST_SCRUB: wb_s = !we_i;
      ST_FAULT: wb_s = 1'b0;
      default:  wb_s = 1'b0;
    endcase
  end

  // Storage, correction latch, registered outputs and statistics.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cw_r    <= 32'd0;
      fix_q_r <= 32'd0;
      data_r  <= 26'd0;
      sec_r   <= 1'b0;
      ded_r   <= 1'b0;
      busy_r  <= 1'b0;
      cnt_r   <= {CNT_WIDTH{1'b0}};
    end else begin
      if (load_s) begin
        cw_r <= hv_i;
      end else if (wb_s) begin
        cw_r <= fix_q_r;
      end else begin
        cw_r <= cw_r;
      end
      if (latch_s) begin
        fix_q_r <= fix_s;
      end else begin
        fix_q_r <= fix_q_r;
      end
      data_r <= extract_data(fix_s);
      sec_r  <= wb_s;
      busy_r <= (state_n_s == ST_SCRUB);
      // A new detection outranks a clear of the sticky flag.
      if (set_ded_s) begin
        ded_r <= 1'b1;
      end else if (clr_i) begin
        ded_r <= 1'b0;
      end else begin
        ded_r <= ded_r;
      end
      if (clr_i) begin
        cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (wb_s && (cnt_r != {CNT_WIDTH{1'b1}})) begin
        cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign data_o    = data_r;
  assign sec_o     = sec_r;
  assign ded_o     = ded_r;
  assign sec_cnt_o = cnt_r;
  assign busy_o    = busy_r;

endmodule

// File: tb/tb_hamming32t26d_scrub_reg.sv
// Scenario bench for the SECDED scrub register; expected data travels through a queue
// from the write that creates it to the cycle the corrected word is observed.
module tb_hamming32t26d_scrub_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] hv;
  logic        clr;
  logic [25:0] data_o, data2_o;
  logic        sec_o, ded_o, busy_o, sec2_o, ded2_o, busy2_o;
  logic [7:0]  cnt_o;
  logic [1:0]  cnt2_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [25:0] exp_q[$];
  logic [25:0] exp_d;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hamming32t26d_scrub_reg #(.CNT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .we_i(we), .hv_i(hv), .clr_i(clr),
    .data_o(data_o), .sec_o(sec_o), .ded_o(ded_o), .sec_cnt_o(cnt_o), .busy_o(busy_o)
  );

  hamming32t26d_scrub_reg #(.CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .we_i(we), .hv_i(hv), .clr_i(clr),
    .data_o(data2_o), .sec_o(sec2_o), .ded_o(ded2_o), .sec_cnt_o(cnt2_o), .busy_o(busy2_o)
  );

  function automatic logic [31:0] encode(input logic [25:0] d);
    logic [31:0] v;
    logic        c;
    int          n;
    v = 32'd0;
    n = 0;
    for (int p = 3; p < 32; p++) begin
      if (p != 4 && p != 8 && p != 16) begin
        v[p] = d[n];
        n++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      c = 1'b0;
      for (int p = 3; p < 32; p++) begin
        if ((p & (1 << k)) != 0) c = c ^ v[p];
      end
      v[1 << k] = c;
    end
    v[0] = ^v[31:1];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act !== req) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    else pass_cnt++;
  endtask

  task automatic write(input logic [31:0] v);
    we = 1'b1;
    hv = v;
    step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; hv = 32'd0; clr = 1'b0;
    step(); step();
    total_cnt++;
    if ({data_o, sec_o, ded_o, cnt_o, busy_o} !== 37'd0) $display("FAIL reset: got 0x%0h, expected 0", {data_o, sec_o, ded_o, cnt_o, busy_o});
    else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_clean_write();
    exp_q.push_back(26'h1);
    write(32'h0000000F);
    step();
    exp_d = exp_q.pop_front();
    total_cnt++;
    if (data_o !== exp_d) $display("FAIL clean_data: got 0x%0h, expected 0x%0h", data_o, exp_d);
    else pass_cnt++;
    total_cnt++;
    if ({ded_o, cnt_o, busy_o} !== 10'd0) $display("FAIL clean_flags: got 0x%0h, expected 0", {ded_o, cnt_o, busy_o});
    else pass_cnt++;
  endtask

  task automatic test_scrub(input string name, input logic [31:0] v, input logic [25:0] d);
    exp_q.push_back(d);
    write(v);
    step();
    total_cnt++;
    if (busy_o !== 1'b1 || sec_o !== 1'b0) $display("FAIL %s_busy: got busy=%0b sec=%0b, expected busy=1 sec=0", name, busy_o, sec_o);
    else pass_cnt++;
    step();
    exp_cnt++;
    exp_d = exp_q.pop_front();
    total_cnt++;
    if (sec_o !== 1'b1 || cnt_o !== 8'(exp_cnt) || busy_o !== 1'b0 || data_o !== exp_d)
      $display("FAIL %s_done: got sec=%0b cnt=%0d busy=%0b data=0x%0h, expected sec=1 cnt=%0d busy=0 data=0x%0h",
               name, sec_o, cnt_o, busy_o, data_o, exp_cnt, exp_d);
    else pass_cnt++;
    chk({name, "_restored"}, dut.cw_r, encode(d));
    step();
    total_cnt++;
    if (sec_o !== 1'b0 || busy_o !== 1'b0 || cnt_o !== 8'(exp_cnt))
      $display("FAIL %s_after: got sec=%0b busy=%0b cnt=%0d, expected 0 0 %0d", name, sec_o, busy_o, cnt_o, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_ded();
    int sec_seen;
    write(32'h0000006F);
    step();
    chk("ded_set", {31'd0, ded_o}, 32'd1);
    sec_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (sec_o) sec_seen++;
    end
    chk("ded_no_sec", 32'(sec_seen), 32'd0);
    chk("ded_no_writeback", dut.cw_r, 32'h0000006F);
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_cnt = 0;
    chk("ded_clr", {23'd0, ded_o, cnt_o}, 32'd0);
    step();
    chk("ded_reenter", {31'd0, ded_o}, 32'd1);
    exp_q.push_back(26'h1);
    we = 1'b1; hv = 32'h0000000F; clr = 1'b1;
    step();
    we = 1'b0; clr = 1'b0;
    step(); step(); step();
    exp_d = exp_q.pop_front();
    total_cnt++;
    if (ded_o !== 1'b0 || busy_o !== 1'b0 || data_o !== exp_d)
      $display("FAIL ded_recover: got ded=%0b busy=%0b data=0x%0h, expected 0 0 0x%0h", ded_o, busy_o, data_o, exp_d);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    exp_q.push_back(26'h1);
    write(32'h0000002F);
    step();
    chk("abort_busy", {31'd0, busy_o}, 32'd1);
    write(32'h0000000F);
    chk("abort_nosec", {30'd0, sec_o, busy_o}, 32'd0);
    step();
    exp_d = exp_q.pop_front();
    total_cnt++;
    if (sec_o !== 1'b0 || cnt_o !== 8'(exp_cnt) || data_o !== exp_d)
      $display("FAIL abort_after: got sec=%0b cnt=%0d data=0x%0h, expected 0 %0d 0x%0h", sec_o, cnt_o, data_o, exp_cnt, exp_d);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    logic [25:0] d;
    int          pos;
    int          to;
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      d   = 26'($urandom);
      pos = $urandom_range(0, 31);
      exp_q.push_back(d);
      write(encode(d) ^ (32'd1 << pos));
      to = 0;
      while (!sec2_o && to < 10) begin
        step();
        to++;
      end
      exp_cnt++;
      exp_d = exp_q.pop_front();
      total_cnt++;
      if (!sec2_o || cnt2_o !== 2'((i > 3) ? 3 : i) || cnt_o !== 8'(exp_cnt) || data2_o !== exp_d)
        $display("FAIL sat_%0d: got sec=%0b cnt2=%0d cnt8=%0d data=0x%0h, expected sec=1 cnt2=%0d cnt8=%0d data=0x%0h",
                 i, sec2_o, cnt2_o, cnt_o, data2_o, (i > 3) ? 3 : i, exp_cnt, exp_d);
      else pass_cnt++;
      step();
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_cnt = 0;
    chk("sat_clr", {22'd0, cnt2_o, cnt_o}, 32'd0);
  endtask

  initial begin
    test_reset();
    test_clean_write();
    test_scrub("scrub_bit5", 32'h0000002F, 26'h1);
    test_scrub("scrub_bit0", 32'h0000000E, 26'h1);
    test_ded();
    test_abort();
    test_scrub("scrub_bit31", encode(26'h2AAAAAA) ^ 32'h80000000, 26'h2AAAAAA);
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hamming32t26d_scrub_reg.md
# hamming32t26d_scrub_reg

Protected storage register that sits directly downstream of the 26-bit Hamming SECDED encoder. It holds the 32-bit encoded vector, decodes it every cycle, and presents corrected 26-bit data. A scrub state machine writes single-bit corrections back into storage, flags double-bit errors, and counts corrected upsets for the SafeSU statistics path.

## Interface
Parameters:
- CNT_WIDTH, 8, width of the saturating corrected-error counter.

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- we_i  input  1  load hv_i into storage at the next edge.
- hv_i  input  32  encoded vector from the encoder: bit 0 = overall parity; bits 1,2,4,8,16 = check bits; all other positions in ascending order = data bits 0..25.
- clr_i  input  1  clears ded_o and sec_cnt_o, and forces FAULT back to IDLE.
- data_o  output  26  registered, corrected data.
- sec_o  output  1  one-cycle pulse when a scrub write-back completes.
- ded_o  output  1  sticky flag for an uncorrectable double error.
- sec_cnt_o  output  CNT_WIDTH  saturating count of completed scrubs.
- busy_o  output  1  high while in the SCRUB state.

## Operation
- Storage register `cw` is 32 bits.
- Decode is combinational on `cw`:
  - Syndrome s[k] (k = 0..4) = XOR of cw[j] for j = 1..31 where bit k of j is set.
  - p = XOR of cw[31:0].
- Classification:
  - s==0 and p==0: clean.
  - p==1: single error (SEC) at position s. s==0 means the overall parity bit itself flipped.
  - s!=0 and p==0: double error (DED).
- Correction:
  - Corrected word `fix` = cw XOR (1 << s) when SEC; otherwise fix = cw.
  - Corrected data = fix at the data positions, mapped to bits 0..25.
- FSM states: IDLE, SCRUB, FAULT.
  - IDLE:
    - we_i: load; stay in IDLE.
    - Else SEC: go to SCRUB; latch fix into `fix_q`.
    - Else DED: go to FAULT; set ded_o.
    - Else: stay in IDLE.
  - SCRUB:
    - we_i: load hv_i. The scrub is aborted, with no count and no pulse. Go to IDLE.
    - Else: cw <= fix_q, sec_o pulses the following cycle, sec_cnt_o increments (saturating), go to IDLE.
  - FAULT:
    - No write-back.
    - we_i: load; go to IDLE.
    - Else clr_i: go to IDLE.
    - Else: stay in FAULT.
- clr_i:
  - Clears ded_o and sec_cnt_o in any state.
  - If clr_i and a SCRUB completion land in the same cycle, clr_i wins and the count stays 0.
  - If clr_i and new DED detection land in the same cycle, the ded_o set wins.
- we_i always has priority over scrub write-back.
- data_o is registered every cycle from the corrected data of the current cw, including in FAULT. In FAULT the data is uncorrected and must not be trusted.
- sec_cnt_o saturates at 2^CNT_WIDTH-1 and never wraps.

## Timing
- Reset values: cw = 0 (a valid codeword), data_o = 0, sec_o = 0, ded_o = 0, sec_cnt_o = 0, busy_o = 0, state = IDLE.
- Write latency: we_i sampled at edge N updates cw at N; data_o shows the decoded data after edge N+1.
- Corrupted-storage scrub timeline:
  - Edge N: detect, IDLE→SCRUB. data_o is already corrected at N+1.
  - Edge N+1: cw rewritten.
  - Cycle after N+1: sec_o = 1 for one cycle; sec_cnt_o has already incremented.
  - busy_o is high between N and N+1.
- DED: ded_o rises after the detecting edge and holds until clr_i.
- Reset asserted mid-scrub returns everything to reset values immediately; no write-back occurs.
- An upset inside cw while in SCRUB is overwritten by fix_q. A new error is detected only on return to IDLE.

## Test plan
- Reset, then write hv_i=0x0000000F (data 0x0000001):
  - data_o=0x0000001 two edges later.
  - ded_o=0, sec_cnt_o=0.
- Write 0x0000002F (bit 5 flipped):
  - One SCRUB cycle with busy_o=1.
  - Stored word restored to 0x0000000F.
  - sec_o pulses once, sec_cnt_o=1, data_o=0x0000001.
- Write 0x0000000E (bit 0 flipped, s=0):
  - Scrub restores 0x0000000F; sec_cnt_o increments.
- Write 0x0000006F (bits 5 and 6 flipped, s=3, p=0):
  - FAULT entered, ded_o=1, no write-back, sec_o stays 0.
  - clr_i → IDLE with ded_o=0. The stored word still holds the DED, so the FSM re-enters FAULT and ded_o returns to 1.
  - Writing 0x0000000F then leaves ded_o=0 and IDLE is held.
- Write 0x0000002F and assert we_i with 0x0000000F during SCRUB:
  - Write wins; sec_o=0, sec_cnt_o unchanged.
- With CNT_WIDTH=2, perform five single-error scrubs:
  - sec_cnt_o reads 1, 2, 3, 3, 3.
  - Then clr_i → 0.
